stream_cipher_engine: RTL and testbench
=======================================

Name: stream_cipher_engine

Overview:
Parametrised successor to the 4-bit LFSR stream cipher. A Galois LFSR of configurable width and tap mask generates a DATA_W-bit keystream word for each accepted input word. The engine XORs that word with the data, so the same path both encrypts and decrypts. The block sits between a message source and sink, uses valid/ready handshakes on both sides, and has a one-word registered output stage.

Parameters:
DATA_W, 8, width of data words and of the keystream word consumed per transfer
LFSR_W, 16, LFSR state width (legal range 4..32)
TAPS, 16'hB400, Galois feedback mask (LFSR_W bits), XORed into the state when the shifted-out bit is 1
DEFAULT_SEED, 1, state loaded at reset; must be nonzero

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
seed_load  in  1  one-cycle strobe: load seed into the LFSR and clear word_count
seed  in  LFSR_W  seed value, sampled when seed_load=1
in_valid  in  1  input word valid
in_ready  out  1  engine can accept a word this cycle
in_data  in  DATA_W  plaintext or ciphertext word
out_valid  out  1  out_data holds a result
out_ready  in  1  sink accepts out_data this cycle
out_data  out  DATA_W  in_data XOR keystream word
key_word  out  DATA_W  keystream word used for the current out_data
word_count  out  16  number of words accepted since the last reset or seed_load (wraps modulo 2^16)

Behaviour:
- Reset (reset=0, asynchronous):
  - lfsr=DEFAULT_SEED, out_valid=0, out_data=0, key_word=0, word_count=0.
  - in_ready goes low while reset is asserted.
- LFSR step:
  - Keystream bit = lfsr[0].
  - Next state = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- Keystream word:
  - Bit i is the output of step i, for i=0..DATA_W-1.
  - The unrolled chain is combinational.
  - The LFSR advances exactly DATA_W steps per accepted word and holds otherwise.
- Handshake:
  - in_ready = !seed_load && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
- On accept:
  - out_data <= in_data ^ kw and key_word <= kw, where kw is the keystream word from the current LFSR state.
  - out_valid <= 1, lfsr advances, word_count increments.
  - Latency is 1 cycle from accept to out_valid.
- Output stage:
  - out_data and key_word stay stable while out_valid=1 && out_ready=0.
  - out_valid clears when out_ready=1 and no new accept occurs in the same cycle.
  - Simultaneous drain and accept gives full throughput, one word per cycle.
- seed_load:
  - Takes priority; no accept occurs in that cycle.
  - lfsr <= (seed==0) ? 1 : seed, since an all-zero seed is replaced with 1 to avoid LFSR lockup.
  - word_count <= 0.
  - A pending out_valid word is kept and drains normally.
- Reset mid-transfer: the pending output word is discarded and out_valid=0 immediately.
- Decryption: an instance seeded identically and fed the ciphertext stream recovers the plaintext.

Decomposition:
- Package stream_cipher_pkg holds:
  - the default tap constants per width (4: 4'hC; 8: 8'hB8; 16: 16'hB400; 32: 32'h80200003);
  - a function lfsr_galois_step(state, taps).
- One sub-module, lfsr_keygen: holds the LFSR register, advance/load controls, combinational key-word output and next-state output.
- The top handles the handshake, the output register and word_count.

Test Plan:
1. LFSR_W=4, TAPS=4'hC, DATA_W=8, seed_load seed=4'h1, then in_data=8'h00 accepted.
   - Expect out_data=8'h59, key_word=8'h59, internal lfsr=4'h7, word_count=1.
2. Same configuration, second word in_data=8'hFF.
   - Expect out_data=8'h70 (keystream 8'h8F), word_count=2.
   - Reseed with 4'h1 and send 8'h00 again: out_data=8'h59.
3. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
   - in_ready=0 after the first accept; out_data stable; lfsr unchanged; exactly one word is consumed.
4. seed_load with seed=0: lfsr=1; the next word produces the same keystream as scenario 1 (8'h59).
5. Round trip: two instances with the same seed, A's out_data feeding B's in_data, a 256-word random stream, out_ready toggled randomly.
   - B's output equals the original plaintext stream.
6. Assert reset while out_valid=1 with out_ready=0.
   - out_valid drops asynchronously; after release lfsr=DEFAULT_SEED and word_count=0.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the stream cipher engine.
// Holds the recommended Galois tap masks per LFSR width and the single-step
// Galois LFSR update used by the keystream generator.
package stream_cipher_pkg;

   localparam logic [3:0]  TAPS_W4  = 4'hC;
   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [31:0] TAPS_W32 = 32'h80200003;

   // One Galois step on a zero-extended state. The caller narrows the result;
   // the upper bits stay zero because the taps are zero-extended as well.
   function automatic logic [31:0] lfsr_galois_step(input logic [31:0] state,
                                                     input logic [31:0] taps);
      return (state >> 1) ^ (state[0] ? taps : 32'd0);
   endfunction

endpackage

// File: rtl/lfsr_keygen.sv
// Galois LFSR keystream generator.
// Holds the LFSR state, produces the DATA_W-bit keystream word for the current
// state combinationally, and advances DATA_W steps when advance_i is high.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (state <= DEFAULT_SEED)
//   load_i     load seed_i into the state (wins over advance_i)
//   seed_i     seed value; zero is replaced by 1
//   advance_i  step the LFSR by one keystream word
//   key_word_o keystream word for the current state
module lfsr_keygen
   import stream_cipher_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              advance_i,
   output logic [DATA_W-1:0] key_word_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] lfsr_next;
   logic [31:0]       chain;

   // Unrolled chain: bit i of the key word is the output bit of step i.
   always_comb begin
      chain      = 32'(lfsr_q);
      key_word_o = '0;
      for (int i = 0; i < DATA_W; i++) begin
         key_word_o[i] = chain[0];
         chain         = lfsr_galois_step(chain, 32'(TAPS));
      end
      lfsr_next = chain[LFSR_W-1:0];
   end

   // An all-zero state would lock the LFSR, so a zero seed loads 1 instead.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
      end else if (advance_i) begin
         lfsr_d = lfsr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= DEFAULT_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/stream_cipher_engine.sv
// LFSR stream cipher engine: out_data = in_data XOR keystream word.
// The same path encrypts and decrypts. Valid/ready on both sides with a
// single registered output word.
// Ports:
//   clk, reset             clock and asynchronous active-low reset
//   seed_load, seed        one-cycle reseed strobe (clears word_count)
//   in_valid/in_ready/in_data     input handshake and word
//   out_valid/out_ready/out_data  output handshake and result word
//   key_word               keystream word used for the current out_data
//   word_count             words accepted since reset or last seed_load
module stream_cipher_engine
   import stream_cipher_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] key_word,
   output logic [15:0]       word_count
);

   logic              accept;
   logic [DATA_W-1:0] kw;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [DATA_W-1:0] key_word_q,  key_word_d;
   logic [15:0]       count_q,     count_d;

   lfsr_keygen #(
      .DATA_W       (DATA_W),
      .LFSR_W       (LFSR_W),
      .TAPS         (TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_keygen (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (seed_load),
      .seed_i     (seed),
      .advance_i  (accept),
      .key_word_o (kw)
   );

   // Reset gates in_ready so the source sees "not ready" while held in reset.
   assign in_ready = reset && !seed_load && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      key_word_d  = key_word_q;
      count_d     = count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ kw;
         key_word_d  = kw;
         count_d     = count_q + 16'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (seed_load) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         key_word_q  <= '0;
         count_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         key_word_q  <= key_word_d;
         count_q     <= count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign key_word   = key_word_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_stream_cipher_engine.sv
// Bench for stream_cipher_engine: a 4-bit-LFSR instance checked cycle by cycle
// against a reference model, and a 16-bit encrypt/decrypt pair in series.
module tb_stream_cipher_engine;
   import stream_cipher_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // 4-bit LFSR instance
   logic       s4_seed_load, s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready;
   logic [3:0] s4_seed;
   logic [7:0] s4_in_data, s4_out_data, s4_key_word;
   logic [15:0] s4_word_count;

   stream_cipher_engine #(.DATA_W(8), .LFSR_W(4), .TAPS(TAPS_W4), .DEFAULT_SEED(4'h1)) dut4 (
      .clk(clk), .reset(rst_n), .seed_load(s4_seed_load), .seed(s4_seed),
      .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data),
      .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data),
      .key_word(s4_key_word), .word_count(s4_word_count)
   );

   // 16-bit pair: A encrypts, B decrypts A's output
   logic        a_seed_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic        b_seed_load, b_out_valid, b_out_ready;
   logic [15:0] rt_seed;
   logic [7:0]  a_in_data, a_out_data, a_key_word, b_out_data, b_key_word;
   logic [15:0] a_word_count, b_word_count;

   stream_cipher_engine dut_a (
      .clk(clk), .reset(rst_n), .seed_load(a_seed_load), .seed(rt_seed),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .key_word(a_key_word), .word_count(a_word_count)
   );

   stream_cipher_engine dut_b (
      .clk(clk), .reset(rst_n), .seed_load(b_seed_load), .seed(rt_seed),
      .in_valid(a_out_valid), .in_ready(a_out_ready), .in_data(a_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .key_word(b_key_word), .word_count(b_word_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Keystream word from a state: repeatedly take the low bit, halve, and
   // fold in the taps whenever the bit taken was a one.
   function automatic logic [7:0] ks_word(input logic [31:0] st, input logic [31:0] taps);
      logic [7:0] w = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (st % 2 == 1) begin
            w  = w + 8'(1 << i);
            st = (st / 2) ^ taps;
         end else begin
            st = st / 2;
         end
      end
      return w;
   endfunction

   function automatic logic [31:0] ks_next(input logic [31:0] st, input logic [31:0] taps);
      for (int i = 0; i < 8; i++) st = (st % 2 == 1) ? ((st / 2) ^ taps) : (st / 2);
      return st;
   endfunction

   // Model of the 4-bit instance
   logic [31:0] m_lfsr;
   logic        m_ov;
   logic [7:0]  m_od, m_kw;
   int          m_cnt;

   task automatic model_reset();
      m_lfsr = 32'd1; m_ov = 1'b0; m_od = 8'h00; m_kw = 8'h00; m_cnt = 0;
   endtask

   // One clock of the 4-bit instance; entered and left just after a rising edge.
   task automatic cyc4(input logic sl, input logic [3:0] sd, input logic iv,
                       input logic [7:0] id, input logic ordy);
      logic       exp_ready;
      logic [7:0] kw;
      s4_seed_load = sl; s4_seed = sd; s4_in_valid = iv; s4_in_data = id; s4_out_ready = ordy;
      #1;
      exp_ready = !sl && (!m_ov || ordy);
      check_val("in_ready", 32'(s4_in_ready), 32'(exp_ready));
      if (sl) begin
         m_lfsr = (sd == 4'h0) ? 32'd1 : 32'(sd);
         m_cnt  = 0;
         if (ordy) m_ov = 1'b0;
      end else if (iv && exp_ready) begin
         kw     = ks_word(m_lfsr, 32'(TAPS_W4));
         m_od   = id ^ kw;
         m_kw   = kw;
         m_lfsr = ks_next(m_lfsr, 32'(TAPS_W4));
         m_cnt  = (m_cnt + 1) % 65536;
         m_ov   = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      @(posedge clk); #1;
      check_val("out_valid",  32'(s4_out_valid),  32'(m_ov));
      check_val("out_data",   32'(s4_out_data),   32'(m_od));
      check_val("key_word",   32'(s4_key_word),   32'(m_kw));
      check_val("word_count", 32'(s4_word_count), 32'(m_cnt));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  held;
      logic [15:0] cnt_before;
      logic [31:0] ma_lfsr;
      logic [7:0]  pt_q[$], ct_q[$];
      logic [7:0]  d, kw;
      int sent, recv;

      rst_n = 1'b0;
      s4_seed_load = 0; s4_seed = 0; s4_in_valid = 0; s4_in_data = 0; s4_out_ready = 0;
      a_seed_load = 0; b_seed_load = 0; rt_seed = 0; a_in_valid = 0; a_in_data = 0; b_out_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid",  32'(s4_out_valid),  32'd0);
      check_val("rst_out_data",   32'(s4_out_data),   32'd0);
      check_val("rst_key_word",   32'(s4_key_word),   32'd0);
      check_val("rst_word_count", 32'(s4_word_count), 32'd0);
      check_val("rst_in_ready",   32'(s4_in_ready),   32'd0);
      rst_n = 1'b1;

      // Seed 1, first word 0x00
      cyc4(1, 4'h1, 0, 8'h00, 1);
      cyc4(0, 4'h0, 1, 8'h00, 1);
      check_val("s1_out_data", 32'(s4_out_data), 32'h59);
      check_val("s1_key_word", 32'(s4_key_word), 32'h59);
      check_val("s1_count",    32'(s4_word_count), 32'd1);

      // Second word 0xFF, then reseed and repeat
      cyc4(0, 4'h0, 1, 8'hFF, 1);
      check_val("s2_out_data", 32'(s4_out_data), 32'h70);
      check_val("s2_key_word", 32'(s4_key_word), 32'h8F);
      check_val("s2_count",    32'(s4_word_count), 32'd2);
      cyc4(1, 4'h1, 0, 8'h00, 1);
      cyc4(0, 4'h0, 1, 8'h00, 1);
      check_val("s2_reseed_data", 32'(s4_out_data), 32'h59);

      // Backpressure: one accept then five stalled cycles
      cyc4(0, 4'h0, 0, 8'h00, 1);
      cnt_before = s4_word_count;
      cyc4(0, 4'h0, 1, 8'hA5, 0);
      held = s4_out_data;
      for (int i = 0; i < 5; i++) begin
         cyc4(0, 4'h0, 1, 8'($urandom), 0);
         check_val("bp_stable", 32'(s4_out_data), 32'(held));
      end
      check_val("bp_consumed", 32'(s4_word_count), 32'(cnt_before + 16'd1));
      cyc4(0, 4'h0, 0, 8'h00, 1);
      cyc4(0, 4'h0, 1, 8'h00, 1);

      // Zero seed behaves like seed 1
      cyc4(1, 4'h0, 0, 8'h00, 1);
      cyc4(0, 4'h0, 1, 8'h00, 1);
      check_val("s4_zero_seed", 32'(s4_out_data), 32'h59);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         cyc4(($urandom % 16) == 0, 4'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      end

      // Reset while a word is held back
      cyc4(0, 4'h0, 1, 8'h3C, 0);
      cyc4(0, 4'h0, 0, 8'h00, 0);
      #2 rst_n = 1'b0;
      #1;
      check_val("s6_out_valid", 32'(s4_out_valid), 32'd0);
      check_val("s6_out_data",  32'(s4_out_data),  32'd0);
      check_val("s6_in_ready",  32'(s4_in_ready),  32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_val("s6_count", 32'(s4_word_count), 32'd0);
      cyc4(0, 4'h0, 1, 8'h00, 1);
      check_val("s6_default_seed", 32'(s4_out_data), 32'h59);

      // Round trip through the 16-bit pair
      rt_seed = 16'($urandom_range(1, 65535));
      a_seed_load = 1; b_seed_load = 1;
      @(posedge clk); #1;
      a_seed_load = 0; b_seed_load = 0;
      ma_lfsr = 32'(rt_seed);
      sent = 0; recv = 0;
      for (int cyc = 0; cyc < 5000 && recv < 256; cyc++) begin
         a_in_valid  = (sent < 256) && ($urandom % 4 != 0);
         a_in_data   = 8'($urandom);
         b_out_ready = 1'($urandom);
         #1;
         if (a_in_valid && a_in_ready) begin
            d  = a_in_data;
            kw = ks_word(ma_lfsr, 32'(TAPS_W16));
            ma_lfsr = ks_next(ma_lfsr, 32'(TAPS_W16));
            pt_q.push_back(d);
            ct_q.push_back(d ^ kw);
            sent++;
         end
         if (a_out_valid && a_out_ready) begin
            if (ct_q.size() == 0) check_val("rt_ct_underflow", 32'd1, 32'd0);
            else check_val("rt_ciphertext", 32'(a_out_data), 32'(ct_q.pop_front()));
         end
         if (b_out_valid && b_out_ready) begin
            if (pt_q.size() == 0) check_val("rt_pt_underflow", 32'd1, 32'd0);
            else check_val("rt_plaintext", 32'(b_out_data), 32'(pt_q.pop_front()));
            recv++;
         end
         @(posedge clk); #1;
      end
      a_in_valid = 0; b_out_ready = 0;
      check_val("rt_received", 32'(recv), 32'd256);
      check_val("rt_a_count",  32'(a_word_count), 32'd256);
      check_val("rt_b_count",  32'(b_word_count), 32'd256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
